// File: rtl/slot_allocator.sv
// Lowest-free-first slot allocator with release-by-index.
// Occupancy, population count and full/empty flags are all registered.
module slot_allocator #(
  parameter int INDEX_BW = 3
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    alloc_req_i,
  output logic                    alloc_gnt_o,
  output logic [INDEX_BW-1:0]     alloc_index_o,
  input  logic                    release_en_i,
  input  logic [INDEX_BW-1:0]     release_index_i,
  output logic [(2**INDEX_BW)-1:0] occupancy_o,
  output logic [INDEX_BW:0]       count_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    release_err_o
);

  localparam int N_SLOTS = 2**INDEX_BW;
  localparam int CW      = INDEX_BW + 1;

  logic [INDEX_BW-1:0] free_idx;
  logic                grant;
  logic                rel_ok;
  logic                rel_bad;
  logic [N_SLOTS-1:0]  occ_next;
  logic [CW-1:0]       count_next;

  // Scan downward so the last hit is the lowest free slot.
  always_comb begin
    free_idx = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!occupancy_o[k]) free_idx = k[INDEX_BW-1:0];
    end
  end

  always_comb begin
    grant    = alloc_req_i && !full_o;
    rel_ok   = release_en_i && occupancy_o[release_index_i];
    rel_bad  = release_en_i && !occupancy_o[release_index_i];
    occ_next = occupancy_o;
    if (rel_ok) occ_next[release_index_i] = 1'b0;
    if (grant)  occ_next[free_idx] = 1'b1;
    count_next = count_o + CW'(grant) - CW'(rel_ok);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      occupancy_o   <= '0;
      count_o       <= '0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
      alloc_gnt_o   <= 1'b0;
      alloc_index_o <= '0;
      release_err_o <= 1'b0;
    end else begin
      occupancy_o <= occ_next;
      count_o     <= count_next;
      full_o      <= (count_next == CW'(N_SLOTS));
      empty_o     <= (count_next == '0);
      alloc_gnt_o <= grant;
      if (grant)   alloc_index_o <= free_idx;
      if (rel_bad) release_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator (INDEX_BW=2).
// Directed plan plus randomized traffic against a behavioural model.
module tb_slot_allocator;

  localparam int IBW = 2;
  localparam int NS  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req = 1'b0;
  logic           gnt;
  logic [IBW-1:0] idx;
  logic           rel = 1'b0;
  logic [IBW-1:0] rel_idx = '0;
  logic [NS-1:0]  occ;
  logic [IBW:0]   cnt;
  logic           full;
  logic           empty;
  logic           err;

  int nvec = 0;
  int nbad = 0;

  // behavioural model state
  bit       m_occ [NS];
  bit       m_gnt;
  int       m_idx;
  bit       m_err;

  slot_allocator #(.INDEX_BW(IBW)) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .alloc_req_i     (req),
    .alloc_gnt_o     (gnt),
    .alloc_index_o   (idx),
    .release_en_i    (rel),
    .release_index_i (rel_idx),
    .occupancy_o     (occ),
    .count_o         (cnt),
    .full_o          (full),
    .empty_o         (empty),
    .release_err_o   (err)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) c += m_occ[i];
    return c;
  endfunction

  function automatic logic [NS-1:0] m_vec();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rq, input bit rl, input int ri,
                            input bit rs);
    bit g;
    int k;
    if (rs) begin
      for (int i = 0; i < NS; i++) m_occ[i] = 0;
      m_gnt = 0;
      m_idx = 0;
      m_err = 0;
      return;
    end
    g = rq && (m_count() != NS);
    k = -1;
    for (int i = 0; i < NS; i++) if (k < 0 && !m_occ[i]) k = i;
    if (rl) begin
      if (m_occ[ri]) m_occ[ri] = 0;
      else m_err = 1;
    end
    // the chosen slot was free before the edge, so a release of it errored above
    if (g) begin
      m_occ[k] = 1;
      m_idx = k;
    end
    m_gnt = g;
  endtask

  task automatic compare();
    int c;
    c = m_count();
    chk("occupancy", 32'(occ), 32'(m_vec()));
    chk("count", 32'(cnt), 32'(c));
    chk("full", 32'(full), 32'(c == NS));
    chk("empty", 32'(empty), 32'(c == 0));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("index", 32'(idx), 32'(m_idx));
    chk("release_err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input bit rq, input bit rl, input int ri, input bit rs);
    req = rq;
    rel = rl;
    rel_idx = ri[IBW-1:0];
    rst = rs;
    @(posedge clk);
    model_edge(rq, rl, ri, rs);
    #1;
    compare();
  endtask

  initial begin
    // reset state
    step(0, 0, 0, 1);
    chk("lit_reset_empty", 32'(empty), 32'd1);
    chk("lit_reset_occ", 32'(occ), 32'd0);

    // fill from empty
    for (int i = 0; i < NS; i++) begin
      step(1, 0, 0, 0);
      chk("lit_fill_gnt", 32'(gnt), 32'd1);
      chk("lit_fill_idx", 32'(idx), 32'(i));
    end
    chk("lit_full_occ", 32'(occ), 32'hF);
    chk("lit_full_cnt", 32'(cnt), 32'd4);
    chk("lit_full_flag", 32'(full), 32'd1);

    // requests while full are dropped
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("lit_full_nogrant", 32'(gnt), 32'd0);
    chk("lit_full_hold_idx", 32'(idx), 32'd3);

    // release + request while full: release wins, no grant
    step(1, 1, 1, 0);
    chk("lit_relfull_occ", 32'(occ), 32'hD);
    chk("lit_relfull_cnt", 32'(cnt), 32'd3);
    chk("lit_relfull_gnt", 32'(gnt), 32'd0);
    step(1, 0, 0, 0);
    chk("lit_regrant_idx", 32'(idx), 32'd1);
    chk("lit_regrant_occ", 32'(occ), 32'hF);

    // reach 0101 then release 2 with a request
    step(0, 1, 1, 0);
    step(0, 1, 3, 0);
    chk("lit_0101", 32'(occ), 32'h5);
    step(1, 1, 2, 0);
    chk("lit_swap_idx", 32'(idx), 32'd1);
    chk("lit_swap_occ", 32'(occ), 32'h3);
    chk("lit_swap_cnt", 32'(cnt), 32'd2);

    // error release is sticky until reset
    step(0, 0, 0, 1);
    step(0, 1, 3, 0);
    chk("lit_err_set", 32'(err), 32'd1);
    chk("lit_err_occ", 32'(occ), 32'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("lit_err_sticky", 32'(err), 32'd1);
    step(0, 0, 0, 1);
    chk("lit_err_clear", 32'(err), 32'd0);

    // reset mid-stream discards the request
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("lit_0111", 32'(occ), 32'h7);
    step(1, 0, 0, 1);
    chk("lit_rst_occ", 32'(occ), 32'd0);
    chk("lit_rst_gnt", 32'(gnt), 32'd0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    chk("lit_rst_idx", 32'(idx), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 5,
           int'($urandom_range(0, NS - 1)),
           $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
